// File: rtl/audio_mix_dsm_pkg.sv
// audio_mix_dsm_pkg: constants and register-map types shared by the sound blocks
package audio_mix_dsm_pkg;
  localparam int MIX_HEADROOM = 2;
  localparam int GAIN_UNITY = 8;
  localparam int GAIN_SHIFT = 3;
  localparam logic [3:0] ADR_CTRL = 4'hF;
  typedef struct packed {
    logic clr_clip;
    logic mute;
  } ctrl_t;
  function automatic int mix_width(input int w);
    return w + MIX_HEADROOM;
  endfunction
endpackage

// File: rtl/audio_mix_dsm_dsm1.sv
// dsm1: first-order delta-sigma modulator, carry of the phase accumulator is the bitstream
module dsm1 #(
  parameter int OUTW = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OUTW-1:0] din,
  output logic            dout
);
  logic [OUTW-1:0] fbk;
  logic [OUTW:0] s;
  assign s = {1'b0, din} + {1'b0, fbk};
  always_ff @(posedge clk) begin
    if (reset) begin
      fbk <= '0;
      dout <= 1'b0;
    end else begin
      fbk <= s[OUTW-1:0];
      dout <= s[OUTW];
    end
  end
endmodule

// File: rtl/audio_mix_dsm.sv
// audio_mix_dsm: time-multiplexed gain/mix of NCH channels with saturation, mute and 1-bit DAC
module audio_mix_dsm
  import audio_mix_dsm_pkg::*;
#(
  parameter int NCH = 6,
  parameter int W = 10,
  parameter int GW = 4,
  localparam int OUTW = mix_width(W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [3:0]        adr,
  input  logic [7:0]        din,
  input  logic [NCH*W-1:0]  ch_in,
  input  logic [NCH-1:0]    ch_en,
  output logic [OUTW-1:0]   mix_out,
  output logic              sample_stb,
  output logic              clip,
  output logic              dac_out
);
  localparam int CW = $clog2(NCH);
  localparam int TW = W + GW - GAIN_SHIFT;
  localparam int AW = TW + CW;
  localparam int SW = AW > OUTW ? AW : OUTW + 1;
  logic [CW-1:0] ch;
  logic [GW-1:0] gain [NCH];
  logic [AW-1:0] acc;
  logic [W-1:0] smp;
  logic [W+GW-1:0] prod;
  logic [TW-1:0] term;
  logic [SW-1:0] sum;
  logic [OUTW-1:0] mix_sat;
  logic mute, done, ovf, ctrl_wr, set_clip, unused;
  ctrl_t ctrl;
  assign smp = ch_en[ch] ? ch_in[ch*W +: W] : '0;
  assign prod = (W+GW)'(smp) * (W+GW)'(gain[ch]);
  assign term = prod[W+GW-1:GAIN_SHIFT];
  // acc holds the complete previous frame while done is high
  assign sum = SW'(acc);
  assign ovf = |(sum >> OUTW);
  assign mix_sat = ovf ? '1 : sum[OUTW-1:0];
  assign ctrl = ctrl_t'(din[1:0]);
  assign ctrl_wr = wr && adr == ADR_CTRL;
  assign set_clip = done && !mute && ovf;
  assign unused = ^{din, prod[GAIN_SHIFT-1:0]};
  always_ff @(posedge clk) begin
    if (reset) begin
      ch <= '0;
      acc <= '0;
      done <= 1'b0;
      mix_out <= '0;
      sample_stb <= 1'b0;
      clip <= 1'b0;
      mute <= 1'b0;
      for (int k = 0; k < NCH; k++) gain[k] <= GW'(GAIN_UNITY);
    end else begin
      ch <= ch == CW'(NCH-1) ? '0 : ch + 1'b1;
      acc <= ch == '0 ? AW'(term) : acc + AW'(term);
      done <= ch == CW'(NCH-1);
      sample_stb <= done;
      if (done) mix_out <= mute ? '0 : mix_sat;
      clip <= set_clip | (clip & ~(ctrl_wr & ctrl.clr_clip));
      if (ctrl_wr) mute <= ctrl.mute;
      for (int k = 0; k < NCH; k++) if (wr && adr == 4'(k)) gain[k] <= din[GW-1:0];
    end
  end
  dsm1 #(.OUTW(OUTW)) u_dsm (
    .clk(clk),
    .reset(reset),
    .din(mix_out),
    .dout(dac_out)
  );
endmodule

// File: tb/tb_audio_mix_dsm.sv
// tb_audio_mix_dsm: frame-level reference model with per-cycle compare plus directed literal checks
module tb_audio_mix_dsm;
  localparam int NCH = 6;
  localparam int W = 10;
  localparam int FULL = 4095;
  logic clk = 1'b0;
  logic reset, wr;
  logic [3:0] adr;
  logic [7:0] din;
  logic [NCH*W-1:0] ch_in;
  logic [NCH-1:0] ch_en;
  logic [11:0] mix_out;
  logic sample_stb, clip, dac_out;
  int vectors = 0;
  int miscompares = 0;
  int n, msum, mpsum, mmix, mfbk;
  int mgain [NCH];
  bit mpend, mstb, mclip, mmute, mdac, armed;
  audio_mix_dsm #(.NCH(NCH), .W(W), .GW(4)) dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .adr(adr),
    .din(din),
    .ch_in(ch_in),
    .ch_en(ch_en),
    .mix_out(mix_out),
    .sample_stb(sample_stb),
    .clip(clip),
    .dac_out(dac_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask
  // Model: sample k of the frame is taken on the k-th clock after reset; the
  // frame total becomes visible one clock after its last sample.
  always @(posedge clk) begin
    int s, k, t;
    bit clr, setc;
    if (reset) begin
      armed = 1;
      n = 0; msum = 0; mpsum = 0; mmix = 0; mfbk = 0;
      mpend = 0; mstb = 0; mclip = 0; mmute = 0; mdac = 0;
      for (int i = 0; i < NCH; i++) mgain[i] = 8;
    end else begin
      s = mmix + mfbk;
      mdac = s >= 4096;
      mfbk = s % 4096;
      mstb = mpend;
      clr = wr && adr == 4'hF && din[1];
      setc = mpend && !mmute && mpsum > FULL;
      if (mpend) mmix = mmute ? 0 : (mpsum > FULL ? FULL : mpsum);
      mclip = setc ? 1'b1 : (clr ? 1'b0 : mclip);
      k = n % NCH;
      t = ch_en[k] ? (int'(ch_in[k*W +: W]) * mgain[k]) / 8 : 0;
      msum = k == 0 ? t : msum + t;
      mpend = k == NCH - 1;
      mpsum = msum;
      n++;
      if (wr && adr == 4'hF) mmute = din[0];
      if (wr && adr < NCH) mgain[adr] = int'(din[3:0]);
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("mix_out", int'(mix_out), mmix);
      chk("sample_stb", int'(sample_stb), int'(mstb));
      chk("clip", int'(clip), int'(mclip));
      chk("dac_out", int'(dac_out), int'(mdac));
    end
  end
  task automatic wreg(input logic [3:0] a, input logic [7:0] d);
    wr = 1'b1; adr = a; din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask
  task automatic wait_stb();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sample_stb) break;
    end
    chk("stb_seen", int'(sample_stb), 1);
  endtask
  task automatic ticks(input int c);
    repeat (c) @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt, p;
    bit found;
    reset = 1'b1; wr = 1'b0; adr = '0; din = '0; ch_in = '0; ch_en = '0;
    ticks(3);
    reset = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      cnt += int'(dac_out);
    end
    chk("idle_dac_ones", cnt, 0);
    chk("idle_mix", int'(mix_out), 0);
    chk("idle_clip", int'(clip), 0);
    ch_in = {{5{10'd1023}}, 10'd512};
    ch_en = 6'b000001;
    found = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mix_out == 12'd512) begin found = 1; break; end
    end
    chk("mix_512_within_12", int'(found), 1);
    wait_stb();
    cnt = 0;
    repeat (4096) begin
      @(negedge clk);
      cnt += int'(dac_out);
    end
    chk("dac_ones_4096", cnt, 512);
    wait_stb();
    p = 0;
    do begin @(negedge clk); p++; end while (!sample_stb && p < 20);
    chk("stb_period", p, 6);
    ch_in = {6{10'd1023}};
    ch_en = 6'h3F;
    for (int k = 0; k < NCH; k++) wreg(4'(k), 8'd15);
    ticks(14);
    chk("overload_mix", int'(mix_out), 4095);
    chk("overload_clip", int'(clip), 1);
    wait_stb();
    ticks(5);
    wreg(4'hF, 8'h02);
    chk("clr_on_load_stb", int'(sample_stb), 1);
    chk("clr_vs_set_clip", int'(clip), 1);
    for (int k = 0; k < NCH; k++) wreg(4'(k), 8'd1);
    ticks(14);
    chk("gain1_mix", int'(mix_out), 762);
    chk("gain1_clip_sticky", int'(clip), 1);
    wreg(4'hF, 8'h02);
    chk("clip_cleared", int'(clip), 0);
    ticks(14);
    chk("gain1_mix_after_clr", int'(mix_out), 762);
    chk("gain1_clip_stays_0", int'(clip), 0);
    wreg(4'd2, 8'd8);
    ch_in = {6{10'd1000}};
    ch_en = 6'b000100;
    wreg(4'hF, 8'h01);
    ticks(14);
    chk("muted_mix", int'(mix_out), 0);
    chk("muted_clip", int'(clip), 0);
    wreg(4'hF, 8'h00);
    ticks(14);
    chk("unmuted_mix", int'(mix_out), 1000);
    ch_in = {6{10'd800}};
    ch_en = 6'b001000;
    wreg(4'd3, 8'd8);
    ticks(14);
    chk("ch3_mix", int'(mix_out), 800);
    wait_stb();
    ticks(3);
    wreg(4'd3, 8'h10);
    wait_stb();
    chk("old_gain_frame", int'(mix_out), 800);
    wait_stb();
    chk("new_gain_frame", int'(mix_out), 0);
    wait_stb();
    ticks(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mix", int'(mix_out), 0);
    chk("rst_stb", int'(sample_stb), 0);
    chk("rst_clip", int'(clip), 0);
    chk("rst_dac", int'(dac_out), 0);
    p = 0;
    do begin @(negedge clk); p++; end while (!sample_stb && p < 20);
    chk("first_stb_after_reset", p, 7);
    chk("gain_default_after_reset", int'(mix_out), 800);
    ticks(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/audio_mix_dsm.md
AUDIO_MIX_DSM -- requirements
Module: audio_mix_dsm

Interface
REQ-001 SHALL have parameter NCH, default 6: number of audio channels (2..15).
REQ-002 SHALL have parameter W, default 10: per-channel unsigned sample width.
REQ-003 SHALL have parameter GW, default 4: per-channel gain width. Gain is unsigned; 8 = unity.
REQ-004 SHALL have derived constant OUTW = W+2: mix width.
REQ-005 SHALL have port clk, input, 1: single clock for the whole block.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port wr, input, 1: register write strobe, one clk per write.
REQ-008 SHALL have port adr, input, 4: register address.
REQ-009 SHALL have port din, input, 8: register write data.
REQ-010 SHALL have port ch_in, input, NCH*W: channel samples; channel k occupies bits [k*W +: W].
REQ-011 SHALL have port ch_en, input, NCH: per-channel enable; a 0 bit makes that channel contribute 0.
REQ-012 SHALL have port mix_out, output, OUTW: current mixed sample.
REQ-013 SHALL have port sample_stb, output, 1: one-clk pulse when mix_out updates.
REQ-014 SHALL have port clip, output, 1: sticky saturation flag.
REQ-015 SHALL have port dac_out, output, 1: first-order delta-sigma bitstream.

Function
REQ-016 Register map SHALL be:
- adr < NCH with wr: gain[adr] <= din[GW-1:0].
- adr 4'hF with wr: din[0] -> mute; din[1]=1 -> clear clip (self-clearing, not stored).
- Other addresses: ignored.
REQ-017 Mixing SHALL be time-multiplexed with channel counter ch = 0..NCH-1, advancing every clk and wrapping NCH-1 -> 0.
REQ-018 Each clk the term (ch_en[ch] ? ch_in[ch] : 0) * gain[ch] >> 3 (W+GW-3 bits, truncating) SHALL be added to the accumulator. At ch=0 the accumulator loads the term instead of adding.
REQ-019 Accumulator width SHALL be W+GW-3+clog2(NCH); no internal overflow is permitted.
REQ-020 On the clk where ch = NCH-1, the final sum, including that channel's term, SHALL be registered into mix_out on the next edge. sample_stb SHALL be 1 in the same cycle mix_out changes.
REQ-021 Latency from a channel being sampled to mix_out reflecting it SHALL be at most NCH clks. The sample rate is clk/NCH.
REQ-022 If the sum exceeds 2^OUTW-1, mix_out SHALL be 2^OUTW-1 and clip SHALL set.
REQ-023 When mute=1, the frame load SHALL write 0 into mix_out and SHALL NOT set clip. Mute takes effect only at frame boundaries.
REQ-024 If clear-clip and a new saturation occur in the same clk, set SHALL win.
REQ-025 A gain write SHALL apply from the next clk; channels already accumulated in the current frame keep the old gain.
REQ-026 Delta-sigma SHALL run every clk: s = {0,mix_out} + {0,fbk} (OUTW+1 bits); fbk <= s[OUTW-1:0]; dac_out <= s[OUTW].
REQ-027 Over any 2^OUTW consecutive clks with mix_out constant at M, dac_out SHALL be 1 exactly M times.
REQ-028 ch_in SHALL be sampled only when its channel index is current; no input handshake is required.

Reset
REQ-029 On reset, the block SHALL set:
- ch = 0, accumulator = 0, mix_out = 0, fbk = 0.
- dac_out = 0, sample_stb = 0, clip = 0, mute = 0.
- all gain = 8.
REQ-030 Reset mid-frame SHALL discard the partial sum. The first sample_stb after release SHALL occur exactly NCH+1 clks after reset deasserts.

Structure
REQ-031 OUTW, the unity gain constant (8) and the register addresses (0xF) SHALL reside in a shared audio package used by other sound blocks.
REQ-032 The delta-sigma modulator SHALL be a separate sub-module dsm1 (parameter OUTW; ports clk, reset, din, dout) so the PSG and beep paths can reuse it.

Verification (NCH=6, W=10, GW=4, OUTW=12)
REQ-033 Reset then idle: mix_out=0, dac_out=0 for 100 clks, clip=0. Writing a gain and reading back via mix confirms default 8.
REQ-034 ch0=512, ch_en=6'b000001, others 1023: mix_out=512 within 12 clks. dac_out count over 4096 clks = 512. sample_stb period = 6 clks.
REQ-035 All channels 1023, all gains 15: each term 1918, sum 11508. mix_out=4095, clip=1. Clear-clip while still overloaded: clip stays 1. Gains set to 1 (sum 762): clear-clip -> clip=0, mix_out=762.
REQ-036 ch2=1000 gain 8, mute=1: next frame mix_out=0, clip unchanged. Mute=0: next frame mix_out=1000.
REQ-037 Gain write to ch3 (16 -> truncated to 0 for din=8'h10) mid-frame after ch3 sampled: current frame uses old gain, next frame reflects 0.
REQ-038 Reset asserted at ch=3 for 1 clk: all outputs 0, gains 8, first sample_stb 7 clks after release.
